serial_adder: RTL and testbench

Bit-serial N-bit adder built around two instances of the team's `half_adder` cell (ports a, b, s, c), which form a full adder, plus a registered carry. It accepts a pair of operands on a start pulse and shifts them LSB-first through the adder, one bit per clock. It presents a registered sum and carry-out with a one-cycle done pulse. It sits directly downstream of the `half_adder` cell and is the next DUT for the same interface/test-class bench structure.

---
 rtl/serial_adder.sv | 115 +++++++++++
 tb/tb_serial_adder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: two half_adder cells form a full adder around a carry flop,
// operands shifted LSB-first one bit per clock, result presented with a done pulse.

module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

// state | meaning
// IDLE  | waiting for start; operands loaded on the accepting edge
// SHIFT | one operand bit added per clock, LSB first
// DONE  | result registered on entry; single-cycle done pulse
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sa, sb, acc, acc_sh;
   logic             cy;
   logic [CW-1:0]    cnt;
   logic             ha1_s, ha1_c, ha2_c, bit_s, carry_nx;
   logic             load, last;

   half_adder u_ha1 (.a(sa[0]), .b(sb[0]), .s(ha1_s), .c(ha1_c));
   half_adder u_ha2 (.a(ha1_s), .b(cy),    .s(bit_s), .c(ha2_c));

   assign carry_nx = ha1_c | ha2_c;

   // Shift-right with the new sum bit entering at the MSB; also correct for WIDTH=1.
   always_comb begin
      acc_sh            = acc >> 1;
      acc_sh[WIDTH-1]   = bit_s;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == LAST) begin
               last     = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx != IDLE);
         done  <= (state_nx == DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa   <= '0;
         sb   <= '0;
         acc  <= '0;
         cy   <= 1'b0;
         cnt  <= '0;
         sum  <= '0;
         cout <= 1'b0;
      end else if (load) begin
         sa  <= a;
         sb  <= b;
         acc <= '0;
         cy  <= 1'b0;
         cnt <= '0;
      end else if (state == SHIFT) begin
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         acc <= acc_sh;
         cy  <= carry_nx;
         cnt <= cnt + CW'(1);
         if (last) begin
            sum  <= acc_sh;
            cout <= carry_nx;
         end
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 and WIDTH=1 instances, results
// predicted at stimulus time into queues and compared when done pulses.

module tb_serial_adder;
   logic       clk;
   logic       rst_n;
   logic       start8, start1;
   logic [7:0] a8, b8, sum8;
   logic [0:0] a1, b1, sum1;
   logic       busy8, done8, cout8;
   logic       busy1, done1, cout1;

   logic [8:0] sb8[$];
   logic [1:0] sb1[$];
   logic [8:0] last8;
   int         n_vec;
   int         n_err;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
         $error("miscompare on %s", tag);
      end
   endtask

   // Called right after the accepting edge; returns in the DONE cycle.
   task automatic wait_done8(input bit noise);
      int         cycles;
      logic [8:0] exp;
      cycles = 0;
      while (done8 !== 1'b1 && cycles < 20) begin
         chk("busy_in_shift", 32'(busy8), 32'd1);
         chk("result_held", 32'({cout8, sum8}), 32'(last8));
         if (noise) begin
            if (cycles == 2) begin
               start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
            end else begin
               start8 = 1'b0;
            end
         end
         step();
         cycles++;
      end
      start8 = 1'b0;
      chk("latency", 32'(cycles), 32'd8);
      if (sb8.size() > 0) exp = sb8.pop_front();
      else exp = 'x;
      chk("done_pulse", 32'(done8), 32'd1);
      chk("busy_in_done", 32'(busy8), 32'd1);
      chk("result", 32'({cout8, sum8}), 32'(exp));
      last8 = exp;
   endtask

   task automatic add8(input logic [7:0] ta, input logic [7:0] tb);
      a8 = ta; b8 = tb; start8 = 1'b1;
      step();
      start8 = 1'b0;
      sb8.push_back({1'b0, ta} + {1'b0, tb});
      wait_done8(1'b0);
      step();
      chk("done_fall", 32'(done8), 32'd0);
      chk("busy_fall", 32'(busy8), 32'd0);
      chk("result_after", 32'({cout8, sum8}), 32'(last8));
   endtask

   initial begin
      logic [1:0] e1;
      logic [1:0] pa [4];
      n_vec = 0; n_err = 0; last8 = '0;
      rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
      a8 = '0; b8 = '0; a1 = '0; b1 = '0;

      // reset then idle
      repeat (3) step();
      chk("reset_busy", 32'(busy8), 32'd0);
      chk("reset_result", 32'({cout8, sum8}), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_busy_done", 32'({busy8, done8}), 32'd0);
         chk("idle_result", 32'({cout8, sum8}), 32'd0);
      end

      // basic add and full carry ripple
      add8(8'h3C, 8'h42);
      add8(8'hFF, 8'h01);
      add8(8'hFF, 8'hFF);

      // start while busy: ignored in SHIFT and DONE, held start accepted in IDLE
      a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
      step();
      start8 = 1'b0;
      sb8.push_back(9'h030);
      wait_done8(1'b1);
      a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
      step();
      chk("ignored_in_done", 32'({busy8, done8}), 32'd0);
      chk("single_result", 32'({cout8, sum8}), 32'h030);
      step();
      chk("held_start_accept", 32'(busy8), 32'd1);
      start8 = 1'b0;
      sb8.push_back(9'h0FF);
      wait_done8(1'b0);
      step();
      chk("idle_after_held", 32'(busy8), 32'd0);

      // reset mid-operation
      a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
      step();
      start8 = 1'b0;
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_ctl", 32'({busy8, done8}), 32'd0);
      chk("async_reset_result", 32'({cout8, sum8}), 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      last8 = '0;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("no_done_after_abort", 32'({busy8, done8}), 32'd0);
         chk("aborted_not_shown", 32'({cout8, sum8}), 32'd0);
      end
      add8(8'h01, 8'h01);

      // WIDTH=1, start held high: accept every third edge
      pa[0] = 2'b00; pa[1] = 2'b01; pa[2] = 2'b10; pa[3] = 2'b11;
      start1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a1 = pa[i][1:1]; b1 = pa[i][0:0];
         step();
         sb1.push_back({1'b0, a1} + {1'b0, b1});
         chk("w1_busy_accept", 32'({busy1, done1}), 32'b10);
         step();
         chk("w1_done", 32'({busy1, done1}), 32'b11);
         e1 = (sb1.size() > 0) ? sb1.pop_front() : 'x;
         chk("w1_result", 32'({cout1, sum1}), 32'(e1));
         step();
         chk("w1_idle", 32'({busy1, done1}), 32'b00);
      end
      start1 = 1'b0;
      chk("w8_queue_empty", 32'(sb8.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
